// File: rtl/pp_fetch_scheduler_pkg.sv
// Shared types and constants for the ping-pong fetch scheduler.
package pp_fetch_scheduler_pkg;

   // Life cycle of one BRAM bank: empty, being written by the buffer, holding a tile.
   typedef enum logic [1:0] {
      BANK_FREE    = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

   // Job-level sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } top_state_e;

   // Every tile lands at the start of its bank.
   localparam int BRAM_BASE = 0;

endpackage

// File: rtl/pp_bank_tracker.sv
// Fill/drain bookkeeping for the two ping-pong banks. fill_bank resets to 0 so
// it agrees with the buffer, whose reset is released together with ours.
module pp_bank_tracker
   import pp_fetch_scheduler_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic fill_start,    // read command issued into fill_bank
   input  logic fill_done,     // outstanding read command completed
   input  logic release_req,   // consumer release, already gated to active jobs
   output logic fill_bank,
   output logic fill_free,     // bank[fill_bank] can accept a new command
   output logic tile_valid,
   output logic tile_bank,
   output logic tile_taken     // a presented tile was released this cycle
);

   logic       fill_bank_q, fill_bank_d;
   logic       drain_bank_q, drain_bank_d;
   logic [1:0] is_free;
   logic [1:0] is_full;

   assign tile_valid = is_full[drain_bank_q];
   assign tile_bank  = drain_bank_q;
   assign tile_taken = release_req && tile_valid;
   assign fill_free  = is_free[fill_bank_q];
   assign fill_bank  = fill_bank_q;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_bank
         localparam logic ME = 1'(gi);
         bank_state_e state_q, state_d;

         // A bank never fills and drains at once, so at most one branch applies.
         always_comb begin
            state_d = state_q;
            if (fill_start && fill_bank_q == ME)
               state_d = BANK_FILLING;
            else if (fill_done && fill_bank_q == ME)
               state_d = BANK_FULL;
            else if (tile_taken && drain_bank_q == ME)
               state_d = BANK_FREE;
         end

         // Bank state register.
         always_ff @(posedge clk) begin
            if (rst) state_q <= BANK_FREE;
            else     state_q <= state_d;
         end

         assign is_free[gi] = (state_q == BANK_FREE);
         assign is_full[gi] = (state_q == BANK_FULL);
      end
   endgenerate

   // Fill pointer advances on completion, drain pointer on release.
   always_comb begin
      fill_bank_d  = fill_done  ? ~fill_bank_q  : fill_bank_q;
      drain_bank_d = tile_taken ? ~drain_bank_q : drain_bank_q;
   end

   // Bank pointer registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_bank_q  <= 1'b0;
         drain_bank_q <= 1'b0;
      end else begin
         fill_bank_q  <= fill_bank_d;
         drain_bank_q <= drain_bank_d;
      end
   end

endmodule

// File: rtl/pp_fetch_scheduler.sv
// Tile-fetch job sequencer: issues one buffer read per tile into alternating
// banks and hands filled banks to the consumer in order.
module pp_fetch_scheduler
   import pp_fetch_scheduler_pkg::*;
#(
   parameter int DDR_ADDR_WIDTH  = 29,
   parameter int BURST_LEN_WIDTH = 8,
   parameter int NUM_BURST_WIDTH = 8,
   parameter int BRAM_ADDR_WIDTH = 10,
   parameter int TILE_CNT_WIDTH  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_start,
   input  logic [DDR_ADDR_WIDTH-1:0]  job_base_addr,
   input  logic [TILE_CNT_WIDTH-1:0]  job_num_tiles,
   input  logic [DDR_ADDR_WIDTH-1:0]  job_tile_stride,
   input  logic [BURST_LEN_WIDTH-1:0] job_burst_len,
   input  logic [NUM_BURST_WIDTH-1:0] job_num_burst,
   output logic                       job_busy,
   output logic                       job_done,
   output logic                       rd_start,
   output logic [DDR_ADDR_WIDTH-1:0]  rd_start_addr,
   output logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
   output logic [NUM_BURST_WIDTH-1:0] rd_num_burst,
   output logic [BRAM_ADDR_WIDTH-1:0] rd_start_bram_addr,
   input  logic                       rd_ready,
   input  logic                       rd_done,
   output logic                       tile_valid,
   output logic                       tile_bank,
   output logic [TILE_CNT_WIDTH-1:0]  tile_index,
   input  logic                       tile_release
);

   top_state_e                 state_q, state_d;
   logic [DDR_ADDR_WIDTH-1:0]  addr_q;
   logic [DDR_ADDR_WIDTH-1:0]  stride_q;
   logic [BURST_LEN_WIDTH-1:0] len_q;
   logic [NUM_BURST_WIDTH-1:0] nb_q;
   logic [TILE_CNT_WIDTH-1:0]  num_q;
   logic [TILE_CNT_WIDTH-1:0]  issued_q;
   logic [TILE_CNT_WIDTH-1:0]  released_q;
   logic                       zero_done_q;

   logic accept;
   logic issue_cmd;
   logic drain_done;
   logic fill_done;
   logic release_req;
   logic fill_bank;
   logic fill_free;
   logic tile_taken;

   // Completions and releases only count while a job is active.
   assign fill_done   = (state_q == ST_WAIT) && rd_done;
   assign release_req = (state_q != ST_IDLE) && tile_release;

   pp_bank_tracker u_banks (
      .clk         (clk),
      .rst         (rst),
      .fill_start  (issue_cmd),
      .fill_done   (fill_done),
      .release_req (release_req),
      .fill_bank   (fill_bank),
      .fill_free   (fill_free),
      .tile_valid  (tile_valid),
      .tile_bank   (tile_bank),
      .tile_taken  (tile_taken)
   );

   // Job FSM: one outstanding command at a time, then wait for the consumer.
   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      issue_cmd  = 1'b0;
      drain_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (job_start) begin
               accept = 1'b1;
               // An empty job finishes from IDLE via zero_done_q.
               if (job_num_tiles != '0) state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (issued_q == num_q) begin
               state_d = ST_DRAIN;
            end else if (fill_free && rd_ready) begin
               issue_cmd = 1'b1;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (rd_done) state_d = ST_ISSUE;
         end
         ST_DRAIN: begin
            if (released_q == num_q) begin
               drain_done = 1'b1;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Job field latches, tile counters and the DDR address generator.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q      <= '0;
         stride_q    <= '0;
         len_q       <= '0;
         nb_q        <= '0;
         num_q       <= '0;
         issued_q    <= '0;
         released_q  <= '0;
         zero_done_q <= 1'b0;
      end else begin
         zero_done_q <= accept && (job_num_tiles == '0);
         if (accept) begin
            addr_q     <= job_base_addr;
            stride_q   <= job_tile_stride;
            len_q      <= job_burst_len;
            nb_q       <= job_num_burst;
            num_q      <= job_num_tiles;
            issued_q   <= '0;
            released_q <= '0;
         end else begin
            if (fill_done) begin
               issued_q <= issued_q + TILE_CNT_WIDTH'(1);
               // Natural wrap at the top of the DDR address space.
               addr_q   <= addr_q + stride_q;
            end
            if (tile_taken)
               released_q <= released_q + TILE_CNT_WIDTH'(1);
         end
      end
   end

   assign job_done           = drain_done || zero_done_q;
   assign job_busy           = (state_q != ST_IDLE) || zero_done_q;
   assign rd_start           = issue_cmd;
   assign rd_start_addr      = addr_q;
   assign rd_burst_len       = len_q;
   assign rd_num_burst       = nb_q;
   assign rd_start_bram_addr = BRAM_ADDR_WIDTH'(BRAM_BASE);
   assign tile_index         = released_q;

endmodule

// File: tb/tb_pp_fetch_scheduler.sv
// Directed bench for pp_fetch_scheduler: inputs change on the falling edge,
// outputs are checked 1 ns later, the DUT samples on the rising edge.
module tb_pp_fetch_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        job_start;
   logic [28:0] job_base_addr;
   logic [15:0] job_num_tiles;
   logic [28:0] job_tile_stride;
   logic [7:0]  job_burst_len;
   logic [7:0]  job_num_burst;
   logic        job_busy;
   logic        job_done;
   logic        rd_start;
   logic [28:0] rd_start_addr;
   logic [7:0]  rd_burst_len;
   logic [7:0]  rd_num_burst;
   logic [9:0]  rd_start_bram_addr;
   logic        rd_ready;
   logic        rd_done;
   logic        tile_valid;
   logic        tile_bank;
   logic [15:0] tile_index;
   logic        tile_release;

   int n_total = 0;
   int n_pass  = 0;

   pp_fetch_scheduler dut (
      .clk                (clk),
      .rst                (rst),
      .job_start          (job_start),
      .job_base_addr      (job_base_addr),
      .job_num_tiles      (job_num_tiles),
      .job_tile_stride    (job_tile_stride),
      .job_burst_len      (job_burst_len),
      .job_num_burst      (job_num_burst),
      .job_busy           (job_busy),
      .job_done           (job_done),
      .rd_start           (rd_start),
      .rd_start_addr      (rd_start_addr),
      .rd_burst_len       (rd_burst_len),
      .rd_num_burst       (rd_num_burst),
      .rd_start_bram_addr (rd_start_bram_addr),
      .rd_ready           (rd_ready),
      .rd_done            (rd_done),
      .tile_valid         (tile_valid),
      .tile_bank          (tile_bank),
      .tile_index         (tile_index),
      .tile_release       (tile_release)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to the next falling edge and drop all one-cycle pulses.
   task automatic cyc();
      @(negedge clk);
      job_start    = 1'b0;
      rd_done      = 1'b0;
      tile_release = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_job(input logic [28:0] base, input logic [15:0] num,
                          input logic [28:0] stride, input logic [7:0] len,
                          input logic [7:0] nb);
      job_start       = 1'b1;
      job_base_addr   = base;
      job_num_tiles   = num;
      job_tile_stride = stride;
      job_burst_len   = len;
      job_num_burst   = nb;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"},  job_busy, 1'b0);
      chk({tag, "_done"},  job_done, 1'b0);
      chk({tag, "_rds"},   rd_start, 1'b0);
      chk({tag, "_addr"},  rd_start_addr, 29'h0);
      chk({tag, "_len"},   rd_burst_len, 8'h0);
      chk({tag, "_nb"},    rd_num_burst, 8'h0);
      chk({tag, "_baddr"}, rd_start_bram_addr, 10'h0);
      chk({tag, "_tv"},    tile_valid, 1'b0);
      chk({tag, "_tb"},    tile_bank, 1'b0);
      chk({tag, "_ti"},    tile_index, 16'h0);
   endtask

   initial begin
      rst = 1'b1; job_start = 1'b0; rd_done = 1'b0; tile_release = 1'b0;
      rd_ready = 1'b1;
      job_base_addr = '0; job_num_tiles = '0; job_tile_stride = '0;
      job_burst_len = '0; job_num_burst = '0;

      // ---- reset state ----
      cyc(); cyc(); settle();
      chk_all_zero("reset");
      rst = 1'b0;

      // ---- 4-tile job: base 0x1000, stride 0x200, len 15, nb 2 ----
      cyc(); set_job(29'h1000, 16'd4, 29'h200, 8'd15, 8'd2); settle();
      chk("j1_busy_at_start", job_busy, 1'b0);
      cyc(); settle();                                   // ISSUE tile 0
      chk("j1_rds0", rd_start, 1'b1);
      chk("j1_addr0", rd_start_addr, 29'h1000);
      chk("j1_len", rd_burst_len, 8'd15);
      chk("j1_nb", rd_num_burst, 8'd2);
      chk("j1_busy", job_busy, 1'b1);
      cyc(); rd_done = 1'b1; settle();                   // WAIT
      chk("j1_no_rds_in_wait", rd_start, 1'b0);
      cyc(); settle();                                   // tile 0 full, issue tile 1
      chk("j1_tv0", tile_valid, 1'b1);
      chk("j1_tb0", tile_bank, 1'b0);
      chk("j1_ti0", tile_index, 16'd0);
      chk("j1_rds1", rd_start, 1'b1);
      chk("j1_addr1", rd_start_addr, 29'h1200);
      $display("tile 0 presented bank %0d, tile 1 issued at 0x%0h", tile_bank, rd_start_addr);
      cyc(); rd_done = 1'b1; settle();                   // both banks become full
      cyc(); settle();
      chk("stall_no_rds_a", rd_start, 1'b0);
      chk("stall_tv", tile_valid, 1'b1);
      cyc(); tile_release = 1'b1; settle();              // release 3 cycles after tile_valid
      chk("stall_no_rds_b", rd_start, 1'b0);
      cyc(); settle();                                   // rd_start one cycle after release
      chk("stall_rds_after_rel", rd_start, 1'b1);
      chk("j1_addr2", rd_start_addr, 29'h1400);
      chk("j1_tb1", tile_bank, 1'b1);
      chk("j1_ti1", tile_index, 16'd1);
      $display("tile 1 presented bank %0d, tile 2 issued at 0x%0h", tile_bank, rd_start_addr);
      cyc(); rd_done = 1'b1; tile_release = 1'b1; settle();  // simultaneous, opposite banks
      chk("sim_tv_before", tile_valid, 1'b1);
      cyc(); settle();
      chk("sim_tv_after", tile_valid, 1'b1);
      chk("sim_tb2", tile_bank, 1'b0);
      chk("sim_ti2", tile_index, 16'd2);
      chk("sim_rds3", rd_start, 1'b1);
      chk("j1_addr3", rd_start_addr, 29'h1600);
      $display("tile 2 presented bank %0d, tile 3 issued at 0x%0h", tile_bank, rd_start_addr);
      cyc(); rd_done = 1'b1; settle();
      cyc(); tile_release = 1'b1; settle();              // all issued, going to drain
      chk("j1_no_rds4", rd_start, 1'b0);
      chk("j1_ti2_hold", tile_index, 16'd2);
      cyc(); tile_release = 1'b1; settle();
      chk("j1_tb3", tile_bank, 1'b1);
      chk("j1_ti3", tile_index, 16'd3);
      chk("j1_done_early", job_done, 1'b0);
      cyc(); settle();
      chk("j1_done", job_done, 1'b1);
      chk("j1_busy_done", job_busy, 1'b1);
      cyc(); settle();
      chk("j1_done_single", job_done, 1'b0);
      chk("j1_idle_busy", job_busy, 1'b0);
      chk("j1_idle_tv", tile_valid, 1'b0);
      $display("job 1 complete");

      // ---- zero-tile job ----
      cyc(); set_job(29'h2000, 16'd0, 29'h10, 8'd1, 8'd1); settle();
      cyc(); settle();
      chk("z_done", job_done, 1'b1);
      chk("z_no_rds_a", rd_start, 1'b0);
      cyc(); settle();
      chk("z_done_single", job_done, 1'b0);
      chk("z_no_rds_b", rd_start, 1'b0);
      $display("zero-tile job complete");

      // ---- stray completion/release while idle ----
      cyc(); rd_done = 1'b1; tile_release = 1'b1; settle();
      cyc(); settle();
      chk("idle_tv", tile_valid, 1'b0);
      chk("idle_ti", tile_index, 16'd0);
      chk("idle_busy", job_busy, 1'b0);

      // ---- address wrap, ignored job_start, reset mid-job ----
      cyc(); set_job(29'h1FFFFF00, 16'd3, 29'h200, 8'd3, 8'd4); settle();
      cyc(); settle();
      chk("w_addr0", rd_start_addr, 29'h1FFFFF00);
      chk("w_rds0", rd_start, 1'b1);
      cyc(); rd_done = 1'b1; set_job(29'h0, 16'd9, 29'h4, 8'd9, 8'd9); settle();
      chk("w_busy", job_busy, 1'b1);
      cyc(); settle();
      chk("w_addr1_wrap", rd_start_addr, 29'h100);
      chk("w_rds1", rd_start, 1'b1);
      chk("w_len_kept", rd_burst_len, 8'd3);
      cyc(); rd_done = 1'b1; settle();
      cyc(); tile_release = 1'b1; settle();
      chk("w_stall", rd_start, 1'b0);
      cyc(); settle();
      chk("w_addr2", rd_start_addr, 29'h300);
      chk("w_rds2", rd_start, 1'b1);
      cyc(); rst = 1'b1; settle();                       // WAIT, bank 1 full
      chk("w_tv_bank1_full", tile_valid, 1'b1);
      chk("w_tb_bank1", tile_bank, 1'b1);
      cyc(); rst = 1'b0; settle();
      chk_all_zero("midrst");
      $display("wrap job aborted by reset");

      // ---- fresh 2-tile job after reset fills bank 0 first ----
      cyc(); set_job(29'h4000, 16'd2, 29'h40, 8'd7, 8'd1); settle();
      cyc(); settle();
      chk("r_rds0", rd_start, 1'b1);
      chk("r_addr0", rd_start_addr, 29'h4000);
      cyc(); rd_done = 1'b1; settle();
      cyc(); settle();
      chk("r_tv0", tile_valid, 1'b1);
      chk("r_tb0", tile_bank, 1'b0);
      chk("r_addr1", rd_start_addr, 29'h4040);
      cyc(); rd_done = 1'b1; settle();
      cyc(); tile_release = 1'b1; settle();
      cyc(); tile_release = 1'b1; settle();
      chk("r_tb1", tile_bank, 1'b1);
      chk("r_ti1", tile_index, 16'd1);
      cyc(); settle();
      chk("r_done", job_done, 1'b1);
      cyc(); settle();
      chk("r_idle", job_busy, 1'b0);
      $display("post-reset job complete");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/pp_fetch_scheduler.md
# pp_fetch_scheduler

Sequencing controller for the ping-pong DDR-to-BRAM read buffer. It accepts one tile-fetch job (base address, tile count, stride, burst shape) and issues one buffer read command per tile, alternating BRAM0/BRAM1. It tracks the fill/drain state of both banks and presents completed tiles to a downstream consumer in order. It sits between the job-issuing control logic and the ping-pong buffer's `rd_*` command port.

## Interface
- `DDR_ADDR_WIDTH`, 29: DDR byte-address width.
- `BURST_LEN_WIDTH`, 8: burst-length field width.
- `NUM_BURST_WIDTH`, 8: bursts-per-command field width.
- `BRAM_ADDR_WIDTH`, 10: BRAM word-address width.
- `TILE_CNT_WIDTH`, 16: tile counter width.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `job_start` in 1: one-cycle job launch; ignored while `job_busy`.
- `job_base_addr` in DDR_ADDR_WIDTH: DDR address of tile 0.
- `job_num_tiles` in TILE_CNT_WIDTH: tiles in the job.
- `job_tile_stride` in DDR_ADDR_WIDTH: address increment per tile.
- `job_burst_len` in BURST_LEN_WIDTH: per-tile burst length.
- `job_num_burst` in NUM_BURST_WIDTH: per-tile burst count.
- `job_busy` out 1: job in progress.
- `job_done` out 1: one-cycle pulse after the last tile is released.
- `rd_start` out 1: one-cycle read-command pulse to the buffer.
- `rd_start_addr` out DDR_ADDR_WIDTH: DDR address of the current tile.
- `rd_burst_len` out BURST_LEN_WIDTH: latched `job_burst_len`.
- `rd_num_burst` out NUM_BURST_WIDTH: latched `job_num_burst`.
- `rd_start_bram_addr` out BRAM_ADDR_WIDTH: constant 0.
- `rd_ready` in 1: buffer read engine idle.
- `rd_done` in 1: one-cycle pulse when the current command completes; the buffer toggles its bank on this pulse.
- `tile_valid` out 1: a full bank is available to the consumer.
- `tile_bank` out 1: bank of the presented tile (0 = BRAM0).
- `tile_index` out TILE_CNT_WIDTH: job-relative index of the presented tile.
- `tile_release` in 1: consumer has finished with the presented bank; honoured only while `tile_valid` is high.

## Operation
- Reset: all outputs are 0; both banks FREE; `fill_bank` = 0 and `drain_bank` = 0.
  - `fill_bank` must match the buffer's reset bank, so the buffer's reset is released in the same cycle as `rst`.
- Each bank has three states: FREE → FILLING (on `rd_start`) → FULL (on `rd_done`) → FREE (on `tile_release` of that bank).
- Top FSM states:
  - IDLE: on `job_start`, latch all job fields, clear `issued`/`released`/`fetched` counters, go to ISSUE. If `job_num_tiles` = 0, pulse `job_done` the next cycle, stay IDLE, and issue no fetch.
  - ISSUE: when `issued < num_tiles`, bank[`fill_bank`] is FREE and `rd_ready` = 1, pulse `rd_start` and go to WAIT. If all tiles have been issued, go to DRAIN.
  - WAIT: on `rd_done`, mark bank[`fill_bank`] FULL, toggle `fill_bank`, increment `issued`, and add `job_tile_stride` to `rd_start_addr` (wraps modulo 2^DDR_ADDR_WIDTH). Return to ISSUE.
  - DRAIN: when `released == num_tiles`, pulse `job_done` and go to IDLE.
- At most one command is outstanding; `rd_start` is never asserted in WAIT.
- Consumer side:
  - `tile_valid` = bank[`drain_bank`] is FULL; `tile_bank` = `drain_bank`.
  - `tile_valid && tile_release`: free that bank, toggle `drain_bank`, increment `released` and `tile_index`.
  - Tiles are delivered strictly in order 0, 1, 2, ….
- Simultaneous `rd_done` and `tile_release` on opposite banks: both take effect in that cycle.
- `job_busy` is high from the cycle after an accepted `job_start` through the `job_done` cycle.
- `rd_done` or `tile_release` received in IDLE is ignored.
- `rst` asserted mid-job discards the job immediately and returns everything to the reset state.

## Timing
- `job_start` → first `rd_start`: 1 cycle (registered), when `rd_ready` = 1.
- `rd_done` → `tile_valid`: 1 cycle later.
- `rd_done` → next `rd_start`: 1 cycle later, if the target bank is FREE.
- `tile_release` → bank FREE at that clock edge → `rd_start` into that bank 1 cycle later at the earliest.
- Last `tile_release` → `job_done`: 1 cycle later.
- `rd_start_addr`, `rd_burst_len` and `rd_num_burst` are stable from the `rd_start` cycle until `rd_done`.

## Structure
- Shared package holds:
  - bank-state enum (FREE, FILLING, FULL);
  - top-state enum (IDLE, ISSUE, WAIT, DRAIN);
  - constant `BRAM_BASE` = 0.
- One natural sub-module, `pp_bank_tracker`, owns the two bank-state registers, `fill_bank`, `drain_bank` and the `tile_valid` logic.
- The top level holds the job FSM, counters and address generator.

## Test plan
- Job base 0x1000, stride 0x200, 4 tiles, len 15, nb 2, consumer releases 3 cycles after `tile_valid`:
  - `rd_start_addr` = 0x1000, 0x1200, 0x1400, 0x1600;
  - `tile_bank` = 0, 1, 0, 1;
  - one `job_done` pulse.
- Consumer stalls (no release) for 3 tiles: after 2 `rd_done` pulses both banks are FULL and no third `rd_start` occurs. The first release produces `rd_start` exactly 1 cycle later.
- `rd_done` and `tile_release` in the same cycle: both banks' states update, `tile_valid` is continuous, no tile is lost or duplicated.
- `job_num_tiles` = 0: `job_done` pulses 1 cycle after `job_start`, and `rd_start` never asserts.
- Base 0x1FFFFF00 with stride 0x200 at width 29: second `rd_start_addr` = 0x00000100. A `job_start` while busy is ignored.
- `rst` during WAIT with bank 1 FULL: all outputs are 0 the next cycle. A new 2-tile job then fills bank 0 first.
